// File: rtl/vga_text_ctrl.sv
// Character console writer: turns a byte stream into glyph writes on the 80x30 framebuffer, plus clear.
// Latency: printable char accepted -> font_rd next cycle -> wr two cycles after that; 1 char / 3 cycles.
// Backpressure: in_ready low outside IDLE, during a pending clear, or while clr_req/rst are high. Macro: VGA_TEXT_CLEAR_ON_RST_EN.
module vga_text_ctrl #(
  parameter int COLS    = 80,
  parameter int ROWS    = 30,
  parameter int GLYPH_W = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic               clr_req,
  output logic               font_rd,
  output logic [7:0]         font_addr,
  input  logic [GLYPH_W-1:0] font_data,
  output logic               wr,
  output logic [GLYPH_W-1:0] w_data,
  output logic [6:0]         w_col,
  output logic [4:0]         w_row,
  output logic [6:0]         cur_col,
  output logic [4:0]         cur_row,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, CLEAR} state_t;

`ifdef VGA_TEXT_CLEAR_ON_RST_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  state_t     state, state_nx;
  logic       pend;      // clear requested while a character was in flight
  logic       blank;     // current WRITE is a backspace erase, not a glyph
  logic [6:0] clr_col;
  logic [4:0] clr_row;
  logic       accept;
  logic       printable;
  logic       last_cell;
  logic       at_home;
  logic [4:0] row_inc;

  assign in_ready  = (state == IDLE) && !pend && !clr_req && !rst;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE) || pend;
  assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign last_cell = (clr_col == COL_LAST) && (clr_row == ROW_LAST);
  assign at_home   = (cur_col == 7'd0) && (cur_row == 5'd0);
  assign row_inc   = (cur_row == ROW_LAST) ? 5'd0 : cur_row + 5'd1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx = CLEAR;
        end else if (accept) begin
          if (printable)                           state_nx = FETCH;
          else if (in_data == 8'h0C)               state_nx = CLEAR;
          else if ((in_data == 8'h08) && !at_home) state_nx = WRITE;
        end
      end
      FETCH:   state_nx = WRITE;
      WRITE:   state_nx = (pend || clr_req) ? CLEAR : IDLE;
      CLEAR:   if (last_cell) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: font read, framebuffer write port, cursor and clear sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      wr        <= 1'b0;
      font_rd   <= 1'b0;
      font_addr <= 8'd0;
      w_data    <= '0;
      w_col     <= 7'd0;
      w_row     <= 5'd0;
      cur_col   <= 7'd0;
      cur_row   <= 5'd0;
      pend      <= 1'b0;
      blank     <= 1'b0;
      clr_col   <= 7'd0;
      clr_row   <= 5'd0;
    end else begin
      wr      <= 1'b0;
      font_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (printable) begin
              font_rd   <= 1'b1;
              font_addr <= in_data;
              blank     <= 1'b0;
            end else if (in_data == 8'h0D) begin
              cur_col <= 7'd0;
            end else if (in_data == 8'h0A) begin
              cur_col <= 7'd0;
              cur_row <= row_inc;
            end else if (in_data == 8'h08) begin
              // Step back first so the erase lands on the new cursor cell
              if (cur_col != 7'd0) begin
                cur_col <= cur_col - 7'd1;
                blank   <= 1'b1;
              end else if (cur_row != 5'd0) begin
                cur_col <= COL_LAST;
                cur_row <= cur_row - 5'd1;
                blank   <= 1'b1;
              end
            end
          end
        end
        FETCH: begin
          if (clr_req) pend <= 1'b1;
        end
        WRITE: begin
          wr     <= 1'b1;
          w_data <= blank ? '0 : font_data;
          w_col  <= cur_col;
          w_row  <= cur_row;
          if (clr_req) pend <= 1'b1;
          if (!blank) begin
            if (cur_col == COL_LAST) begin
              cur_col <= 7'd0;
              cur_row <= row_inc;
            end else begin
              cur_col <= cur_col + 7'd1;
            end
          end
        end
        CLEAR: begin
          wr     <= 1'b1;
          w_data <= '0;
          w_col  <= clr_col;
          w_row  <= clr_row;
          if (last_cell) begin
            clr_col <= 7'd0;
            clr_row <= 5'd0;
            cur_col <= 7'd0;
            cur_row <= 5'd0;
            pend    <= 1'b0;
          end else if (clr_col == COL_LAST) begin
            clr_col <= 7'd0;
            clr_row <= clr_row + 5'd1;
          end else begin
            clr_col <= clr_col + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Directed bench for vga_text_ctrl: a cell-level console model predicts every framebuffer write and the cursor.
// The bench also provides the 1-cycle-latency font ROM and pins the model with literal expectations.
// Works with or without VGA_TEXT_CLEAR_ON_RST_EN defined.
module tb_vga_text_ctrl;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int GW   = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          clr_req = 1'b0;
  logic          in_ready, font_rd, wr, busy;
  logic [7:0]    font_addr;
  logic [GW-1:0] font_data = '0;
  logic [GW-1:0] w_data;
  logic [6:0]    w_col, cur_col;
  logic [4:0]    w_row, cur_row;

  always #5 clk = ~clk;

  vga_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .GLYPH_W(GW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .clr_req(clr_req), .font_rd(font_rd), .font_addr(font_addr), .font_data(font_data),
    .wr(wr), .w_data(w_data), .w_col(w_col), .w_row(w_row),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  function automatic logic [GW-1:0] glyph(input logic [7:0] c);
    return {c, ~c, 96'hDEADBEEF_CAFEF00D_12345678, 16'hAA55};
  endfunction

  // Font ROM with one cycle of read latency
  always @(posedge clk) if (font_rd) font_data <= glyph(font_addr);

  typedef struct packed {
    logic [GW-1:0] d;
    logic [6:0]    c;
    logic [4:0]    r;
  } wr_t;

  wr_t exp_q[$];
  wr_t got;
  int  m_col = 0, m_row = 0;
  int  n_cmp = 0, n_bad = 0;
  int  wr_cnt = 0;

  task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_wr(input logic [GW-1:0] d, input int c, input int r);
    wr_t e;
    e.d = d; e.c = 7'(c); e.r = 5'(r);
    exp_q.push_back(e);
  endfunction

  function automatic void push_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        push_wr('0, c, r);
    m_col = 0;
    m_row = 0;
  endfunction

  // Console semantics on a linear cell index; called at the edge a character is accepted
  function automatic void model_char(input logic [7:0] c);
    int idx;
    if (c >= 8'h20 && c <= 8'h7E) begin
      push_wr(glyph(c), m_col, m_row);
      idx   = (m_row * COLS + m_col + 1) % (COLS * ROWS);
      m_col = idx % COLS;
      m_row = idx / COLS;
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
    end else if (c == 8'h08) begin
      if (m_row * COLS + m_col > 0) begin
        idx   = m_row * COLS + m_col - 1;
        m_col = idx % COLS;
        m_row = idx / COLS;
        push_wr('0, m_col, m_row);
      end
    end else if (c == 8'h0C) begin
      push_clear();
    end
  endfunction

  // Every cycle: each wr must match the next predicted write; an idle DUT must show the model cursor
  always @(negedge clk) begin
    if (wr) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_wr: got wr at col %0d row %0d, expected no write", w_col, w_row);
      end else begin
        got = exp_q.pop_front();
        check("wr_data", w_data, got.d);
        check("wr_col", GW'(w_col), GW'(got.c));
        check("wr_row", GW'(w_row), GW'(got.r));
      end
    end
    if (!busy && !rst) begin
      check("cur_col", GW'(cur_col), GW'(m_col));
      check("cur_row", GW'(cur_row), GW'(m_row));
    end
  end

  task automatic send(input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = c;
    #1;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 5000 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_char(c);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", GW'(busy), GW'(0));
    #1;
  endtask

  task automatic do_reset();
    int n = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    @(negedge clk);
    check("rst_wr", GW'(wr), GW'(0));
    check("rst_in_ready", GW'(in_ready), GW'(0));
    check("rst_font_rd", GW'(font_rd), GW'(0));
    check("rst_w_data", w_data, '0);
    check("rst_cur_col", GW'(cur_col), GW'(0));
    check("rst_cur_row", GW'(cur_row), GW'(0));
`ifdef VGA_TEXT_CLEAR_ON_RST_EN
    check("rst_busy", GW'(busy), GW'(1));
`else
    check("rst_busy", GW'(busy), GW'(0));
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifdef VGA_TEXT_CLEAR_ON_RST_EN
    push_clear();
`endif
    #1;
    while (!in_ready && n < 3000) begin
      n++;
      @(negedge clk);
      #1;
    end
`ifdef VGA_TEXT_CLEAR_ON_RST_EN
    check("ready_low_cycles_after_rst", GW'(n), GW'(2400));
`else
    check("ready_low_cycles_after_rst", GW'(n), GW'(0));
`endif
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int w0;
    do_reset();

    // 'A' at home: font read, then the write of the ROM glyph at (0,0)
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h41;
    #1 check("A_in_ready", GW'(in_ready), GW'(1));
    @(posedge clk);
    model_char(8'h41);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("A_font_rd", GW'(font_rd), GW'(1));
    check("A_font_addr", GW'(font_addr), GW'(8'h41));
    check("A_wr_early", GW'(wr), GW'(0));
    @(negedge clk);
    check("A_font_rd_drop", GW'(font_rd), GW'(0));
    check("A_wr_early2", GW'(wr), GW'(0));
    @(negedge clk);
    check("A_wr", GW'(wr), GW'(1));
    check("A_w_data", w_data, 128'h41BE_DEADBEEF_CAFEF00D_12345678_AA55);
    check("A_w_col", GW'(w_col), GW'(0));
    check("A_w_row", GW'(w_row), GW'(0));
    check("A_cur_col", GW'(cur_col), GW'(1));
    check("A_cur_row", GW'(cur_row), GW'(0));

    // Walk to the last cell and wrap
    for (int i = 0; i < 29; i++) send(8'h0A);
    for (int i = 0; i < 79; i++) send(8'h78);
    wait_idle(100);
    check("corner_col", GW'(cur_col), GW'(79));
    check("corner_row", GW'(cur_row), GW'(29));
    send(8'h42);
    wait_idle(100);
    check("wrap_col", GW'(cur_col), GW'(0));
    check("wrap_row", GW'(cur_row), GW'(0));

    // CR / LF / BS at (5,3)
    for (int i = 0; i < 3; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h79);
    wait_idle(100);
    w0 = wr_cnt;
    send(8'h0D);
    @(negedge clk);
    check("cr_col", GW'(cur_col), GW'(0));
    check("cr_row", GW'(cur_row), GW'(3));
    send(8'h0A);
    @(negedge clk);
    check("lf_row", GW'(cur_row), GW'(4));
    check("crlf_no_wr", GW'(wr_cnt - w0), GW'(0));
    send(8'h08);
    wait_idle(100);
    check("bs_col", GW'(cur_col), GW'(79));
    check("bs_row", GW'(cur_row), GW'(3));
    check("bs_wr", GW'(wr_cnt - w0), GW'(1));

    // Clear request in IDLE beats a simultaneous character
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    clr_req  = 1'b1;
    #1 check("clr_blocks_ready", GW'(in_ready), GW'(0));
    w0 = wr_cnt;
    @(posedge clk);
    push_clear();
    #1;
    clr_req  = 1'b0;
    in_valid = 1'b0;
    wait_idle(3000);
    check("clear_wr_count", GW'(wr_cnt - w0), GW'(2400));
    check("clear_ready_back", GW'(in_ready), GW'(1));
    check("clear_queue_empty", GW'(exp_q.size()), GW'(0));

    // Backspace at home does nothing
    w0 = wr_cnt;
    send(8'h08);
    repeat (4) @(negedge clk);
    check("bs_home_no_wr", GW'(wr_cnt - w0), GW'(0));
    check("bs_home_col", GW'(cur_col), GW'(0));

    // Unknown control code is swallowed
    send(8'h01);
    repeat (2) @(negedge clk);
    check("ctl_no_wr", GW'(wr_cnt - w0), GW'(0));

    // Clear requested during FETCH of 'C': char first, then full clear, busy throughout
    send(8'h43);
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk);
    push_clear();
    #1 clr_req = 1'b0;
    n = 1;
    @(negedge clk);
    while (busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("fetch_clear_busy_len", GW'(n), GW'(2402));
    #1 check("fetch_clear_queue_empty", GW'(exp_q.size()), GW'(0));

    // Reset 1000 cycles into a form-feed clear
    send(8'h0C);
    repeat (1000) @(negedge clk);
    do_reset();
    wait_idle(3000);

    send(8'h51);
    wait_idle(100);
    check("final_queue_empty", GW'(exp_q.size()), GW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
